// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU datapath (master) and the
// data-memory responder (slave). Byte addresses, 16-bit data.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word-organised 16-bit memory behind a
// valid/ready request channel and a valid/ready response channel, with a
// fixed number of wait states between accept and response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flag and suppress odd-address
// accesses; when undefined, addr[0] is ignored and rsp_err stays 0).
module dmem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus,
    output logic             busy
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   mis_q, mis_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;

    logic                   mem_we_c;
    logic                   mis_in_c;
    logic                   unused_addr_c;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    // Address bits above the word index wrap; bit 0 only matters with the check enabled
    assign unused_addr_c = ^bus.req_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_in_c = bus.req_addr[0];
`else
    assign mis_in_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        mis_d       = mis_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        mem_we_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    idx_d       = bus.req_addr[ADDR_BITS:1];
                    wdata_d     = bus.req_wdata;
                    mis_d       = mis_in_c;
                    // Counter spans WAIT_CYCLES+1 cycles before the commit edge
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    state_d     = ST_WAIT;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = mis_q;
                    rsp_rdata_d = (we_q || mis_q) ? '0 : mem_q[idx_q];
                    mem_we_c    = we_q && !mis_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            mis_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            mis_q       <= mis_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Memory array, written only on the commit edge; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written corner
// sequences (reset mid-wait, zero wait states) and random traffic checked
// against a word-array memory model.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int unsigned WAITS = 2;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
    );

    dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    // Reference memory: 512-byte window, words of two bytes
    logic [15:0] mm [256];
    bit          known [256];

    function automatic void model(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                                  output logic [15:0] rd, output logic err, output bit rd_known);
        int unsigned w;
        w        = (int'(addr) % 512) / 2;
        err      = ALIGN_EN && (int'(addr) % 2 == 1);
        rd       = 16'h0000;
        rd_known = 1'b1;
        if (!err) begin
            if (we) begin
                mm[w]    = wd;
                known[w] = 1'b1;
            end else begin
                rd       = mm[w];
                rd_known = known[w];
            end
        end
    endfunction

    // One transaction on the WAITS instance with `hold` cycles of response backpressure
    task automatic txn(input string tag, input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input int hold, input logic [15:0] exp_rd, input logic exp_err, input bit chk_rd);
        int k;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.rsp_ready = 1'b0;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) chk({tag, " req_ready timeout"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, " busy after accept"}, 32'(busy), 32'd1);
        k = 0;
        while (!bus.rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(WAITS + 1));
        if (chk_rd) chk({tag, " rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        chk({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 16'h0100;
            bus.req_wdata = 16'hDEAD;
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
            if (chk_rd) chk({tag, " hold rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " released valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " released req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " released busy"}, 32'(busy), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        int          hold;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    task automatic apply(input int i);
        logic [15:0] rd;
        logic        e;
        bit          kn;
        model(tbl[i].we, tbl[i].addr, tbl[i].wd, rd, e, kn);
        txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].hold,
            tbl[i].exp_rd, tbl[i].exp_err, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, wd, rd;
        logic        we, e;
        bit          kn;
        int          hold;

        tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b1, 16'h0202, 16'h5A5A, 0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 16'h0002, 16'h0000, 0, 16'h5A5A, 1'b0};
        tbl[4]  = '{1'b1, 16'h0040, 16'h1234, 2, 16'h0000, 1'b0};
        tbl[5]  = '{1'b0, 16'h0040, 16'h0000, 5, 16'h1234, 1'b0};
        tbl[6]  = '{1'b1, 16'h0004, 16'h1111, 0, 16'h0000, 1'b0};
        tbl[7]  = '{1'b0, 16'h0004, 16'h0000, 0, 16'h1111, 1'b0};
        tbl[8]  = '{1'b0, 16'h0004, 16'h0000, 0, 16'h1111, 1'b0};
        tbl[9]  = '{1'b1, 16'h0005, 16'hAAAA, 0, 16'h0000, ALIGN_EN};
        tbl[10] = '{1'b0, 16'h0004, 16'h0000, 0, ALIGN_EN ? 16'h1111 : 16'hAAAA, 1'b0};

        for (int i = 0; i < 256; i++) known[i] = 1'b0;

        bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0; bus.rsp_ready  = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) apply(i);

        // Reset during WAIT: outputs return to reset values at once, store is dropped
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0004;
        bus.req_wdata = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstwait busy before", 32'(busy), 32'd1);
        chk("rstwait rdata before", 32'(bus.rsp_rdata), 32'h1111);
        rst_n = 1'b0;
        #1;
        chk("rstwait req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstwait rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstwait rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rstwait busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 8; i < 11; i++) apply(i);

        // Zero wait states: store then load, rsp_ready held high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus0.req_valid = 1'b1;
            bus0.req_we    = (i == 0);
            bus0.req_addr  = 16'h0008;
            bus0.req_wdata = 16'h7777;
            bus0.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus0.req_valid = 1'b0;
            chk($sformatf("w0[%0d] valid at N", i), 32'(bus0.rsp_valid), 32'd0);
            chk($sformatf("w0[%0d] req_ready at N", i), 32'(bus0.req_ready), 32'd0);
            @(negedge clk);
            chk($sformatf("w0[%0d] valid at N+1", i), 32'(bus0.rsp_valid), 32'd1);
            chk($sformatf("w0[%0d] rdata", i), 32'(bus0.rsp_rdata), (i == 0) ? 32'h0 : 32'h7777);
            @(negedge clk);
            chk($sformatf("w0[%0d] valid at N+2", i), 32'(bus0.rsp_valid), 32'd0);
            chk($sformatf("w0[%0d] req_ready at N+2", i), 32'(bus0.req_ready), 32'd1);
            chk($sformatf("w0[%0d] busy at N+2", i), 32'(busy0), 32'd0);
        end
        bus0.rsp_ready = 1'b0;

        // Random traffic over a small word set, with wrap and odd addresses
        for (int n = 0; n < 40; n++) begin
            we      = 1'($urandom_range(0, 1));
            a       = 16'($urandom);
            a[8:5]  = 4'b0000;
            wd      = 16'($urandom);
            hold    = int'($urandom_range(0, 3));
            model(we, a, wd, rd, e, kn);
            txn($sformatf("rnd%0d", n), we, a, wd, hold, rd, e, kn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
